// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 16;
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;
  typedef enum logic [1:0] {ARB_CPU, ARB_LOCK, ARB_FORCE} arb_state_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive denied DMA request cycles.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic ph1,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic hit,
  output logic hit_next
);
  logic [3:0] cnt, cnt_d;
  assign cnt_d = (gnt || !req) ? 4'd0 : hit ? cnt : cnt + 4'd1;
  assign hit = cnt == 4'(LIMIT);
  assign hit_next = cnt_d == 4'(LIMIT);
  always_ff @(posedge ph1) cnt <= reset ? 4'd0 : cnt_d;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: CPU/DMA arbiter for the shared memory bus with lock and starvation bound.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              dma_req,
  input  logic              cpu_rw,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        dma_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rw,
  output logic [7:0]        mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [7:0]        mem_rdata
);
  arb_state_t state, state_d;
  logic lock_q, starve_hit, starve_hit_next;
  logic [1:0] rd_owner_q;
  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .ph1(ph1),
    .reset(reset),
    .req(dma_req),
    .gnt(dma_gnt),
    .hit(starve_hit),
    .hit_next(starve_hit_next)
  );
  assign lock_q = state == ARB_LOCK;
  // A held lock outranks a starved DMA; otherwise the starved DMA outranks the CPU.
  assign cpu_gnt = !reset && cpu_req && (lock_q || !(starve_hit && dma_req));
  assign dma_gnt = !reset && dma_req && !cpu_gnt;
  assign mem_address = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
  assign mem_rw = cpu_gnt ? cpu_rw : dma_gnt ? dma_rw : MEM_RD;
  assign mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : 8'h00;
  assign mem_wdata_oe = (cpu_gnt || dma_gnt) && mem_rw == MEM_WR;
  assign rdata = mem_rdata;
  assign cpu_rvalid = rd_owner_q[1] && !reset;
  assign dma_rvalid = rd_owner_q[0] && !reset;
  // Locks never chain: a locked grant inside ARB_LOCK still returns to normal priority.
  always_comb begin
    state_d = ARB_CPU;
    state_d = (cpu_gnt && cpu_lock && !lock_q) ? ARB_LOCK : starve_hit_next ? ARB_FORCE : ARB_CPU;
  end
  always_ff @(posedge ph1) begin
    state <= reset ? ARB_CPU : state_d;
    rd_owner_q <= reset ? 2'b00 : {cpu_gnt && cpu_rw == MEM_RD, dma_gnt && dma_rw == MEM_RD};
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter and sequencer that shares the single-ported `mem` system (RAM 0x0000–0x0FFF, ROM 0xF000–0xFFFF) between the 6502 core and a DMA/bootload requester. It multiplexes address, direction and write data onto the memory, and returns read data with a valid strobe to the requester that issued the read. CPU has fixed priority, and a starvation counter bounds DMA wait. It sits between the core/DMA engines and `mem` in the chip top; the top-level tristate on `data` is driven from `mem_wdata_oe`.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied DMA request cycles before a forced DMA grant (range 1–15).
- `ph1`  in  1  sole clock; all state updates on posedge `ph1`.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`, `dma_req`  in  1  access request, held until granted.
- `cpu_rw`, `dma_rw`  in  1  1 = read, 0 = write (same sense as `read_write_sel`).
- `cpu_addr`, `dma_addr`  in  16  byte address.
- `cpu_wdata`, `dma_wdata`  in  8  write data.
- `cpu_lock`  in  1  with `cpu_req`, holds the CPU grant through the next cycle (RMW pairs).
- `cpu_gnt`, `dma_gnt`  out  1  combinational: access accepted this cycle.
- `cpu_rvalid`, `dma_rvalid`  out  1  registered: read data valid this cycle.
- `rdata`  out  8  `mem_rdata` pass-through; qualified by the rvalid strobes.
- `mem_address`  out  16  to `mem.address`.
- `mem_rw`  out  1  to `mem.read_write_sel`.
- `mem_wdata`  out  8  data driven to the bus on writes.
- `mem_wdata_oe`  out  1  bus drive enable = granted write.
- `mem_rdata`  in  8  bus data from `mem`.

## Operation
- At most one access per cycle. Grant is combinational from the current requests and registered state.
- Grant rule, in order:
  1. If `lock_q` is set and `cpu_req` is high, grant the CPU.
  2. Else if `starve_cnt == STARVE_LIMIT` and `dma_req` is high, grant DMA.
  3. Else if `cpu_req` is high, grant the CPU.
  4. Else if `dma_req` is high, grant DMA.
  5. Else no grant.
- FSM states:
  - `ARB_CPU`: normal priority.
  - `ARB_LOCK`: entered after a CPU grant with `cpu_lock` high; exits to `ARB_CPU` after one cycle, or immediately if `cpu_req` is low.
  - `ARB_FORCE`: the cycle in which `starve_cnt == STARVE_LIMIT`; returns to `ARB_CPU` after the DMA grant.
- `lock_q` = (state == `ARB_LOCK`). Lock beats starvation: a forced grant waits until the lock releases.
- `starve_cnt` (4 bit):
  - Increments on `dma_req && !dma_gnt`.
  - Clears on `dma_gnt` or `!dma_req`.
  - Saturates at `STARVE_LIMIT`.
- Memory bus:
  - Granted requester's address, rw and wdata drive `mem_address`, `mem_rw`, `mem_wdata`.
  - `mem_wdata_oe` = granted && !rw.
  - No grant: `mem_address` = 0x0000, `mem_rw` = 1, `mem_wdata_oe` = 0.
- Read return:
  - `rd_owner_q` captures {cpu read granted, dma read granted} at the edge.
  - `cpu_rvalid`/`dma_rvalid` = `rd_owner_q` bits.
  - `rdata` is valid in that cycle.
- Writes produce no rvalid. `mem` writes only RAM; writes elsewhere complete silently.

## Timing
- Grant: same cycle as request (0 wait if uncontended).
- Read: address presented in cycle N, `mem` samples at the end of N, rvalid and rdata in N+1. Back-to-back reads give one datum per cycle.
- Write: committed at the edge ending the grant cycle.
- Maximum DMA wait with the CPU always requesting: `STARVE_LIMIT` cycles, plus 1 if a lock is active.
- Reset values:
  - `cpu_rvalid` = `dma_rvalid` = 0; `rd_owner_q` = 0.
  - `starve_cnt` = 0; state = `ARB_CPU`.
  - While `reset` is high, gnts = 0, `mem_wdata_oe` = 0, `mem_rw` = 1.
- Reset mid-read: a read granted in the cycle before `reset` rises never produces rvalid.
- Simultaneous requests with `starve_cnt` below the limit: the CPU wins. A request dropped before grant is not remembered.

## Structure
- `mem_arb_pkg`: `arb_state_t` enum {`ARB_CPU`, `ARB_LOCK`, `ARB_FORCE`}, `MEM_RD`/`MEM_WR` constants, address-width constant.
- One natural sub-module: `arb_starve_ctr` (saturating counter, limit parameter, hit flag).
- Tristate on `data` stays in the top level, not in this block.

## Test plan
- CPU read 0xF000 (ROM preloaded 0xA9), DMA idle → `cpu_gnt` same cycle, `cpu_rvalid` = 1 with `rdata` = 0xA9 next cycle, `dma_rvalid` = 0.
- DMA write 0x0010 ← 0x5A, then CPU read 0x0010 → write granted, `mem_wdata_oe` = 1 for one cycle; CPU rdata = 0x5A.
- CPU requests every cycle, DMA requests continuously, `STARVE_LIMIT` = 4 → DMA granted on exactly the 5th cycle, then CPU regains the grant; repeats with period 5.
- CPU read with `cpu_lock` then write 0x0020, DMA at limit → DMA grant deferred one cycle past the lock; CPU pair uninterrupted.
- CPU read granted, `reset` asserted next cycle → no `cpu_rvalid`; all outputs at reset values; `starve_cnt` = 0 after release.
- No requests → `mem_address` = 0x0000, `mem_rw` = 1, no gnt/rvalid for 20 cycles.
